// File: rtl/clk_div_pkg.sv
// Shared constants for the integer clock divider family.
package clk_div_pkg;

   localparam int unsigned RATIO_WIDTH_DEFAULT = 8;
   localparam int unsigned RATIO_BYPASS        = 0;
   localparam int unsigned MIN_DIV_RATIO       = 2;

endpackage

// File: rtl/clk_div_mux.sv
// 2:1 clock mux wrapping the library clock-mux cell; behavioural model here.
module clk_div_mux (
   input  logic sel,
   input  logic i_clk_a,
   input  logic i_clk_b,
   output logic o_clk
);

   (* dont_touch = "true" *) logic clk_mux;

   assign clk_mux = sel ? i_clk_b : i_clk_a;
   assign o_clk   = clk_mux;

endmodule

// File: rtl/clk_div_gen.sv
// Parametrised integer clock divider: ceil(N/2) high, floor(N/2) low, changes
// applied only at period boundaries, with a ref-domain period tick.
module clk_div_gen
   import clk_div_pkg::*;
#(
   parameter int unsigned RATIO_WIDTH = RATIO_WIDTH_DEFAULT
) (
   input  logic                   i_ref_clk,
   input  logic                   i_rst_n,
   input  logic                   i_clk_en,
   input  logic [RATIO_WIDTH-1:0] i_div_ratio,
   output logic                   o_div_clk,
   output logic                   o_div_tick,
   output logic [RATIO_WIDTH-1:0] o_ratio_active
);

   logic [RATIO_WIDTH-1:0] cnt_q, cnt_d;
   logic [RATIO_WIDTH-1:0] act_ratio_q, act_ratio_d;
   logic [RATIO_WIDTH-1:0] eff_ratio;
   logic [RATIO_WIDTH-1:0] high_len;
   logic [RATIO_WIDTH-1:0] cnt_inc;
   logic                   div_clk_q, div_clk_d;
   logic                   tick_q, tick_d;
   logic                   bypass;
   logic                   boundary;
   logic                   div_sel;

   always_comb begin
      eff_ratio = (i_clk_en && (i_div_ratio >= RATIO_WIDTH'(MIN_DIV_RATIO))) ?
                  i_div_ratio : RATIO_WIDTH'(RATIO_BYPASS);
      bypass    = (act_ratio_q == RATIO_WIDTH'(RATIO_BYPASS));
      boundary  = bypass || (cnt_q == act_ratio_q - RATIO_WIDTH'(1));
      high_len  = act_ratio_q - (act_ratio_q >> 1);
      // cnt stays <= act_ratio-2 off-boundary, so the increment cannot wrap
      cnt_inc   = cnt_q + RATIO_WIDTH'(1);
   end

   always_comb begin
      cnt_d       = cnt_q;
      act_ratio_d = act_ratio_q;
      div_clk_d   = div_clk_q;
      tick_d      = tick_q;
      if (boundary) begin
         act_ratio_d = eff_ratio;
         cnt_d       = '0;
         div_clk_d   = (eff_ratio != RATIO_WIDTH'(RATIO_BYPASS));
         tick_d      = 1'b1;
      end else begin
         cnt_d     = cnt_inc;
         div_clk_d = (cnt_inc < high_len);
         tick_d    = 1'b0;
      end
   end

   always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q       <= '0;
         act_ratio_q <= '0;
         div_clk_q   <= 1'b0;
         tick_q      <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         act_ratio_q <= act_ratio_d;
         div_clk_q   <= div_clk_d;
         tick_q      <= tick_d;
      end
   end

   // Select only moves at boundaries, where div_clk_q is low
   assign div_sel = ~bypass;

   clk_div_mux u_clk_mux (
      .sel     (div_sel),
      .i_clk_a (i_ref_clk),
      .i_clk_b (div_clk_q),
      .o_clk   (o_div_clk)
   );

   assign o_div_tick     = tick_q;
   assign o_ratio_active = act_ratio_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen (RATIO_WIDTH=4): period model plus directed checks.
module tb_clk_div_gen;

   localparam int unsigned W = 4;

   logic         ref_clk = 1'b0;
   logic         rst_n   = 1'b1;
   logic         clk_en  = 1'b0;
   logic [W-1:0] div_ratio = '0;
   logic         div_clk;
   logic         div_tick;
   logic [W-1:0] ratio_active;

   int n_cmp  = 0;
   int n_fail = 0;

   clk_div_gen #(
      .RATIO_WIDTH (W)
   ) dut (
      .i_ref_clk      (ref_clk),
      .i_rst_n        (rst_n),
      .i_clk_en       (clk_en),
      .i_div_ratio    (div_ratio),
      .o_div_clk      (div_clk),
      .o_div_tick     (div_tick),
      .o_ratio_active (ratio_active)
   );

   always #5 ref_clk = ~ref_clk;

   task automatic cmp(input string name, input int actual, input int expected);
      n_cmp++;
      if (actual != expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Model: a period of length N (0 = bypass) and a position within it
   int m_n;
   int m_pos;
   bit m_started;

   always @(posedge ref_clk or negedge rst_n) begin
      if (!rst_n) begin
         m_n       <= 0;
         m_pos     <= 0;
         m_started <= 1'b0;
      end else begin
         if (m_n == 0 || m_pos == m_n - 1) begin
            m_n   <= (clk_en && int'(div_ratio) >= 2) ? int'(div_ratio) : 0;
            m_pos <= 0;
         end else begin
            m_pos <= m_pos + 1;
         end
         m_started <= 1'b1;
      end
   end

   task automatic model_check();
      int exp_clk;
      exp_clk = (m_n == 0) ? int'(ref_clk) : int'(m_pos < (m_n + 1) / 2);
      cmp("model_active", int'(ratio_active), m_n);
      cmp("model_tick", int'(div_tick), int'(m_started && m_pos == 0));
      cmp("model_clk", int'(div_clk), exp_clk);
   endtask

   always @(posedge ref_clk) begin
      #1;
      model_check();
   end

   always @(negedge ref_clk) begin
      #1;
      model_check();
   end

   task automatic wait_tick();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 64 && !seen; i++) begin
         @(negedge ref_clk);
         if (div_tick) seen = 1'b1;
      end
      cmp("wait_tick_timeout", int'(seen), 1);
   endtask

   // Called at the negedge where the tick of a new period is visible
   task automatic check_period(input int n, input int hi);
      for (int i = 0; i < n; i++) begin
         cmp("period_clk", int'(div_clk), int'(i < hi));
         cmp("period_tick", int'(div_tick), int'(i == 0));
         cmp("period_active", int'(ratio_active), n);
         @(negedge ref_clk);
      end
      cmp("period_next_tick", int'(div_tick), 1);
   endtask

   task automatic test_leave(input bit by_en);
      clk_en    = 1'b1;
      div_ratio = 4'd8;
      wait_tick();
      cmp("leave_active_start", int'(ratio_active), 8);
      @(negedge ref_clk);
      @(negedge ref_clk);
      if (by_en) clk_en = 1'b0;
      else       div_ratio = 4'd1;
      for (int i = 3; i < 8; i++) begin
         @(negedge ref_clk);
         cmp("leave_active_hold", int'(ratio_active), 8);
         cmp("leave_clk", int'(div_clk), int'(i < 4));
      end
      @(negedge ref_clk);
      cmp("leave_active_bypass", int'(ratio_active), 0);
      cmp("leave_tick", int'(div_tick), 1);
   endtask

   initial begin
      logic [7:0] exp_clk_bits;
      logic [7:0] exp_tick_bits;

      // 1. reset and bypass
      clk_en    = 1'b0;
      div_ratio = 4'd4;
      #2 rst_n  = 1'b0;
      repeat (2) @(negedge ref_clk);
      cmp("rst_active", int'(ratio_active), 0);
      cmp("rst_tick", int'(div_tick), 0);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge ref_clk);
         cmp("byp_tick", int'(div_tick), 1);
         cmp("byp_active", int'(ratio_active), 0);
      end

      // 2. enable divide-by-4 from bypass
      clk_en = 1'b1;
      @(negedge ref_clk);
      exp_clk_bits  = 8'b1100_1100;
      exp_tick_bits = 8'b1000_1000;
      cmp("div4_active", int'(ratio_active), 4);
      for (int i = 7; i >= 0; i--) begin
         cmp("div4_clk", int'(div_clk), int'(exp_clk_bits[i]));
         cmp("div4_tick", int'(div_tick), int'(exp_tick_bits[i]));
         @(negedge ref_clk);
      end

      // 3. odd ratios, including the largest ratio for W=4
      div_ratio = 4'd5;
      wait_tick();
      check_period(5, 3);
      div_ratio = 4'd15;
      wait_tick();
      check_period(15, 8);

      // 4. ratio change mid-period applies at the boundary
      div_ratio = 4'd4;
      wait_tick();
      cmp("chg_active_4", int'(ratio_active), 4);
      @(negedge ref_clk);
      div_ratio = 4'd6;
      @(negedge ref_clk);
      cmp("chg_hold_cnt2", int'(ratio_active), 4);
      cmp("chg_clk_cnt2", int'(div_clk), 0);
      @(negedge ref_clk);
      cmp("chg_hold_cnt3", int'(ratio_active), 4);
      @(negedge ref_clk);
      cmp("chg_active_6", int'(ratio_active), 6);
      cmp("chg_tick", int'(div_tick), 1);
      check_period(6, 3);

      // 5. leaving divide mode via ratio=1 and via clk_en=0
      test_leave(1'b0);
      test_leave(1'b1);

      // 6. async reset mid high phase
      clk_en    = 1'b1;
      div_ratio = 4'd6;
      wait_tick();
      @(negedge ref_clk);
      cmp("pre_rst_clk_high", int'(div_clk), 1);
      #3 rst_n = 1'b0;
      #1;
      cmp("arst_active", int'(ratio_active), 0);
      cmp("arst_tick", int'(div_tick), 0);
      cmp("arst_clk_low", int'(div_clk), 0);
      @(posedge ref_clk);
      #1;
      cmp("arst_clk_follows", int'(div_clk), 1);
      @(negedge ref_clk);
      rst_n = 1'b1;
      wait_tick();
      cmp("post_rst_active", int'(ratio_active), 6);
      check_period(6, 3);

      repeat (2) @(negedge ref_clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
